var_delay_line: RTL
===================

// Module: var_delay_line
// PURPOSE
//  Beat-gated delay line with a runtime-selectable depth. It replaces a fixed shift-register delay wherever the
//  delay must change on the fly or the data stream is not continuous.
//  Data is written into a circular RAM on every in_valid beat and read back from a tap computed as
//  write pointer minus the delay. It sits on strobed datapaths, e.g. to re-align sprite/pixel data against
//  a variable-latency stage.
// PARAMETERS
//  WIDTH  32  data width in bits
//  DEPTH  16  maximum delay in beats; must be a power of 2, >= 2
//  AW     $clog2(DEPTH)  pointer width (localparam, derived)
// PORTS
//  clk        in   1        clock; all logic on posedge
//  rst_n      in   1        synchronous reset, active low
//  in_valid   in   1        input beat strobe
//  in         in   WIDTH    input sample; captured when in_valid=1
//  delay      in   AW+1     delay in beats; sampled on every beat; legal range 1..DEPTH
//  flush      in   1        synchronous clear of the fill count (RAM contents untouched)
//  out        out  WIDTH    delayed sample, registered; holds value between beats
//  out_valid  out  1        1-cycle strobe: out was updated with a valid delayed sample
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out=0, out_valid=0, wptr=0, fill=0. RAM is not reset.
//    A beat presented during a reset cycle is discarded.
//  - Notation: s_k = the k-th accepted beat since the last reset/flush (k from 0). D = clamped delay.
//  - Clamp: delay=0 -> D=1; delay>DEPTH -> D=DEPTH. Clamping is combinational on the sampled value.
//  - On beat k (in_valid=1, rst_n=1, flush=0):
//      mem[wptr] <= s_k; wptr <= wptr+1, modulo DEPTH (natural AW-bit wrap).
//      out <= s_{k-D+1}: D=1 bypasses in directly; D>1 reads mem[(wptr-(D-1)) mod DEPTH].
//      out_valid <= (fill >= D-1).
//      fill <= min(fill+1, DEPTH-1); fill saturates, never wraps.
//  - Latency: with in_valid held high, out(t+D) = in(t), i.e. identical timing to a D-stage shift register.
//  - On a non-beat cycle: out holds its value, out_valid <= 0, wptr and fill unchanged.
//  - Not-filled beat (fill < D-1): out is still written with the RAM/bypass value (stale data),
//    but out_valid=0. Downstream logic must qualify out with out_valid.
//  - Delay change: takes effect on the first beat that samples the new value; there is no drain.
//      Increase: out_valid drops until fill >= newD-1. If fill is already saturated, older samples are
//        output immediately and may repeat.
//      Decrease: samples are skipped; out jumps forward to s_{k-newD+1}.
//  - flush=1 at posedge: fill <= 0, out_valid <= 0, out holds. A beat presented in the same cycle is discarded.
//    wptr is unchanged.
//  - Precedence: rst_n low > flush > in_valid.
//  - Read and write address the same RAM entry only when D-1 = 0. That case uses the bypass, so the RAM
//    never needs read-during-write behaviour; a 1W1R array with a registered read path is sufficient.
// TESTING (WIDTH=8, DEPTH=16; input ramp s_k = k+1)
//  1. Reset, delay=1, continuous in_valid -> out_valid from the cycle after beat 0, out=0x01,0x02,... in order.
//  2. delay=4, continuous -> out_valid=0 for beats 0-2; the edge after beat 3 gives out=0x01, out_valid=1,
//     then one sample per cycle.
//  3. delay=4, in_valid every 3rd cycle -> exactly one out_valid strobe per beat after beat 3;
//     out holds between beats; no duplicates or gaps.
//  4. delay=16, 40 continuous beats -> beat k outputs k-14 for k>=15; correct across two wptr wraps.
//  5. Saturated stream at delay=4, switch to delay=8 -> next out = s_{k-7}, out_valid stays 1.
//     Then delay=0 -> behaves as 1. Then delay=20 -> behaves as 16.
//  6. rst_n=0 for one cycle mid-stream with in_valid=1 -> out=0, out_valid=0 next cycle; that beat is dropped;
//     refill with delay=4 needs 3 beats. Repeat the check using flush: same response, except out holds.

Source files
------------

// File: rtl/var_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : var_delay_line
// Brief    : Beat-gated delay line with runtime-selectable depth (circular RAM).
// Revision : 1.0  initial release
// ============================================================================
module var_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in,
    input  logic [$clog2(DEPTH):0]     delay,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_FILL_MAX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_fill;

    logic [AW:0]      w_d;
    logic [AW-1:0]    w_dm1;
    logic [AW-1:0]    w_rptr;
    logic             w_beat;

    always_comb begin
        w_d = delay;
        if (delay == '0)
            w_d = (AW+1)'(1);
        else if (delay > C_DEPTH)
            w_d = C_DEPTH;
        w_dm1  = AW'(w_d - (AW+1)'(1));
        w_rptr = r_wptr - w_dm1;
        w_beat = rst_n && !flush && in_valid;
    end

    // RAM is never reset; a beat dropped by reset/flush is not written.
    always_ff @(posedge clk) begin
        if (w_beat)
            r_mem[r_wptr] <= in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            r_wptr    <= '0;
            r_fill    <= '0;
        end else if (flush) begin
            r_fill    <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            r_wptr    <= r_wptr + AW'(1);
            r_fill    <= (r_fill == C_FILL_MAX) ? r_fill : r_fill + AW'(1);
            out_valid <= (r_fill >= w_dm1);
            // D=1 would read the entry being written, so it bypasses the RAM.
            out       <= (w_dm1 == '0) ? in : r_mem[w_rptr];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
